// File: rtl/vga_sprite_engine.sv
// 640x480 VGA timing generator with NUM_SPRITES solid-colour square sprites over a flat background.
// Define VGA_COLLISION_EN to build the sticky sprite-collision register at address 4*NUM_SPRITES.
module vga_sprite_engine #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPRITE_SIZE = 32,
    parameter logic [23:0] BG_COLOR    = 24'h302827
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        frame_start
);
    localparam logic [10:0] SZ        = 11'(SPRITE_SIZE);
    localparam logic [31:0] COLL_ADDR = 32'(4 * NUM_SPRITES);
    localparam logic [31:0] FCNT_ADDR = 32'(4 * NUM_SPRITES + 1);

    logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
    logic        latch, visible;
    logic [NUM_SPRITES-1:0][9:0]  sx_q, sy_q, ax_q, ay_q;
    logic [NUM_SPRITES-1:0]       sen_q, aen_q, hit;
    logic [NUM_SPRITES-1:0][23:0] scol_q, acol_q;
    logic [31:0] fcnt_q, coll_rd;
    logic [23:0] pix_d, rgb_q;
    logic        hsync_d, vsync_d, hsync_q, vsync_q;
    logic        unused_data;

    assign unused_data = ^data_in[30:24];

    always_comb begin
        hcount_d = (hcount_q == 10'd799) ? 10'd0 : hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == 10'd799)
            vcount_d = (vcount_q == 10'd524) ? 10'd0 : vcount_q + 10'd1;
    end

    assign latch       = (hcount_q == 10'd799) && (vcount_q == 10'd479);
    assign visible     = (hcount_q < 10'd640) && (vcount_q < 10'd480);
    assign frame_start = latch;

    // Shadow registers take CPU writes; active registers only change at the latch point,
    // so the latch always copies the pre-write shadow value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sx_q   <= '0;
            sy_q   <= '0;
            sen_q  <= '0;
            scol_q <= '0;
            ax_q   <= '0;
            ay_q   <= '0;
            aen_q  <= '0;
            acol_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (latch) begin
                ax_q   <= sx_q;
                ay_q   <= sy_q;
                aen_q  <= sen_q;
                acol_q <= scol_q;
                fcnt_q <= fcnt_q + 32'd1;
            end
            if (mem_we) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (address == 32'(4 * i))     sx_q[i] <= data_in[9:0];
                    if (address == 32'(4 * i + 1)) sy_q[i] <= data_in[9:0];
                    if (address == 32'(4 * i + 2)) begin
                        sen_q[i]  <= data_in[31];
                        scol_q[i] <= data_in[23:0];
                    end
                end
            end
        end
    end

    // 11-bit compare so sprites near x/y=1023 never wrap back to 0.
    for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_hit
        logic [10:0] x0, y0;
        assign x0 = {1'b0, ax_q[s]};
        assign y0 = {1'b0, ay_q[s]};
        assign hit[s] = aen_q[s]
                     && ({1'b0, hcount_q} >= x0) && ({1'b0, hcount_q} < x0 + SZ)
                     && ({1'b0, vcount_q} >= y0) && ({1'b0, vcount_q} < y0 + SZ);
    end

    always_comb begin
        pix_d = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            if (hit[i]) pix_d = acol_q[i];
        if (!visible) pix_d = '0;
        hsync_d = !((hcount_q >= 10'd656) && (hcount_q <= 10'd751));
        vsync_d = !((vcount_q == 10'd490) || (vcount_q == 10'd491));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            rgb_q    <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            rgb_q    <= pix_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign {R, G, B} = rgb_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;

`ifdef VGA_COLLISION_EN
    localparam logic [NUM_SPRITES-1:0] ONE = NUM_SPRITES'(1);
    logic [NUM_SPRITES-1:0] coll_q, coll_d, coll_set;

    // Set wins over a simultaneous write-one-to-clear.
    always_comb begin
        coll_set = (visible && ((hit & (hit - ONE)) != '0)) ? hit : '0;
        coll_d   = coll_q;
        if (mem_we && (address == COLL_ADDR))
            coll_d = coll_d & ~data_in[NUM_SPRITES-1:0];
        coll_d = coll_d | coll_set;
    end

    always_ff @(posedge clk) begin
        if (rst) coll_q <= '0;
        else     coll_q <= coll_d;
    end

    assign coll_rd = 32'(coll_q);
`else
    assign coll_rd = '0;
`endif

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (address == 32'(4 * i))     data_out = {22'd0, sx_q[i]};
            if (address == 32'(4 * i + 1)) data_out = {22'd0, sy_q[i]};
            if (address == 32'(4 * i + 2)) data_out = {sen_q[i], 7'd0, scol_q[i]};
        end
        if (address == COLL_ADDR) data_out = coll_rd;
        if (address == FCNT_ADDR) data_out = fcnt_q;
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Randomized register traffic plus directed sprite scenes, checked every cycle against a
// frame-position model of the engine.
module tb_vga_sprite_engine;
    localparam int          NS      = 4;
    localparam int          SZ      = 32;
    localparam logic [23:0] BG      = 24'h302827;
    localparam int          FRAME_T = 800 * 525;
    localparam int          LATCH_T = 479 * 800 + 799;
    localparam logic [31:0] COLL_A  = 32'(4 * NS);
    localparam logic [31:0] FCNT_A  = 32'(4 * NS + 1);

    logic        clk, rst, mem_we;
    logic [31:0] address, data_in, data_out;
    logic        hsync, vsync, frame_start;
    logic [7:0]  R, G, B;

    int tests = 0;
    int fails = 0;

    vga_sprite_engine dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .address(address), .data_in(data_in),
        .data_out(data_out), .hsync(hsync), .vsync(vsync), .R(R), .G(G), .B(B),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            if (fails <= 20) $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // ---------------- model: position t within the frame, register file as plain arrays
    bit          m_init = 0;
    int          m_t, m_oh, m_ov, mh, mv, idx;
    int          m_sx[NS], m_sy[NS], m_ax[NS], m_ay[NS];
    bit          m_sen[NS], m_aen[NS];
    logic [23:0] m_scol[NS], m_acol[NS];
    logic [31:0] m_fcnt;
    logic [23:0] e_rgb;
    logic        e_hs, e_vs;
`ifdef VGA_COLLISION_EN
    logic [31:0] m_coll, mset, mclr;
`endif

    function automatic bit covers(int i, int h, int v);
        return m_aen[i] && h >= m_ax[i] && h < m_ax[i] + SZ && v >= m_ay[i] && v < m_ay[i] + SZ;
    endfunction

    function automatic logic [23:0] pix(int h, int v);
        if (!(h < 640 && v < 480)) return 24'h0;
        for (int i = 0; i < NS; i++) if (covers(i, h, v)) return m_acol[i];
        return BG;
    endfunction

    function automatic logic [31:0] mread(logic [31:0] a);
        int i;
        if (a < 32'(4 * NS)) begin
            i = int'(a >> 2);
            case (a[1:0])
                2'd0:    return 32'(m_sx[i]);
                2'd1:    return 32'(m_sy[i]);
                2'd2:    return {m_sen[i], 7'd0, m_scol[i]};
                default: return 32'd0;
            endcase
        end
`ifdef VGA_COLLISION_EN
        if (a == COLL_A) return m_coll;
`endif
        if (a == FCNT_A) return m_fcnt;
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_t = 0; m_oh = -1; m_ov = -1;
            for (int i = 0; i < NS; i++) begin
                m_sx[i] = 0; m_sy[i] = 0; m_sen[i] = 0; m_scol[i] = 0;
                m_ax[i] = 0; m_ay[i] = 0; m_aen[i] = 0; m_acol[i] = 0;
            end
            m_fcnt = 0; e_rgb = 0; e_hs = 1; e_vs = 1;
`ifdef VGA_COLLISION_EN
            m_coll = 0;
`endif
        end else if (m_init) begin
            mh = m_t % 800;
            mv = m_t / 800;
            m_oh = mh; m_ov = mv;
            e_rgb = pix(mh, mv);
            e_hs  = !(mh >= 656 && mh <= 751);
            e_vs  = !(mv == 490 || mv == 491);
`ifdef VGA_COLLISION_EN
            mset = 0; mclr = 0;
            if (mh < 640 && mv < 480)
                for (int i = 0; i < NS; i++) if (covers(i, mh, mv)) mset[i] = 1'b1;
            if ($countones(mset) < 2) mset = 0;
`endif
            if (m_t == LATCH_T) begin
                for (int i = 0; i < NS; i++) begin
                    m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_aen[i] = m_sen[i]; m_acol[i] = m_scol[i];
                end
                m_fcnt = m_fcnt + 32'd1;
            end
            if (mem_we && address < 32'(4 * NS)) begin
                idx = int'(address >> 2);
                case (address[1:0])
                    2'd0: m_sx[idx] = int'(data_in[9:0]);
                    2'd1: m_sy[idx] = int'(data_in[9:0]);
                    2'd2: begin m_sen[idx] = data_in[31]; m_scol[idx] = data_in[23:0]; end
                    default: ;
                endcase
            end
`ifdef VGA_COLLISION_EN
            if (mem_we && address == COLL_A) mclr = data_in;
            m_coll = (m_coll & ~mclr) | mset;
`endif
            m_t = (m_t + 1) % FRAME_T;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("rgb", {R, G, B}, e_rgb);
            chk("hsync", hsync, e_hs);
            chk("vsync", vsync, e_vs);
            chk("frame_start", frame_start, (m_t == LATCH_T));
            chk("data_out", data_out, mread(address));
        end
    end

    // ---------------- stimulus
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1'b1; address = a; data_in = d;
        cyc();
        mem_we = 1'b0;
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            mem_we  = 1'($urandom_range(0, 1));
            address = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4 * NS + 3));
            data_in = $urandom;
        end
        cyc();
        mem_we = 1'b0;
    endtask

    task automatic probe(input string nm, input int h, input int v, input logic [23:0] lit);
        int n;
        n = 0;
        while (!(m_oh == h && m_ov == v) && n < FRAME_T + 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= FRAME_T + 10000) begin
            tests++; fails++;
            $display("FAIL %s: pixel (%0d,%0d) never reached", nm, h, v);
        end else begin
            chk(nm, {R, G, B}, lit);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; mem_we = 1'b0; address = '0; data_in = '0;
        repeat (3) cyc();
        rst = 1'b0;
        rand_cycles(1500);
        wr(32'd0, 32'h155);

        // reset in the middle of the hsync pulse
        n = 0;
        while (m_t % 800 != 700 && n < 1000) begin cyc(); n++; end
        address = 32'd0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rgb", {R, G, B}, 24'h0);
        chk("rst_hsync", hsync, 1'b1);
        chk("rst_vsync", vsync, 1'b1);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_shadow_x0", data_out, 32'h0);

        rand_cycles(1500);
        wr(32'd0, 32'd100); wr(32'd1, 32'd10);  wr(32'd2, 32'h80FF0000);
        wr(32'd4, 32'd200); wr(32'd5, 32'd20);  wr(32'd6, 32'h800000FF);
        wr(32'd8, 32'd210); wr(32'd9, 32'd30);  wr(32'd10, 32'h8000FF00);
        wr(32'd12, 32'd620); wr(32'd13, 32'd5); wr(32'd14, 32'h80ABCDEF);
        probe("pre_latch_no_sprite", 100, 10, BG);

        // write X during the latch cycle: old value must be used this frame
        n = 0;
        while (m_t != LATCH_T && n < FRAME_T) begin cyc(); n++; end
        mem_we = 1'b1; address = 32'd0; data_in = 32'd300;
        @(negedge clk);
        chk("frame_start_at_latch", frame_start, 1'b1);
        cyc();
        mem_we = 1'b0;
        @(negedge clk);
        chk("shadow_new_x", data_out, 32'd300);
        cyc();
        address = FCNT_A;
        @(negedge clk);
        chk("frame_count", data_out, 32'd1);
        cyc();

        probe("row5_left_bg", 0, 5, BG);
        probe("s3_before", 619, 5, BG);
        probe("s3_left", 620, 5, 24'hABCDEF);
        probe("s3_right", 639, 5, 24'hABCDEF);
        probe("blank_640", 640, 5, 24'h0);
        probe("s0_topleft_oldx", 100, 10, 24'hFF0000);
        probe("s0_topright", 131, 10, 24'hFF0000);
        probe("s0_right_edge_bg", 132, 10, BG);
        probe("overlap_low_index", 215, 35, 24'h0000FF);
        probe("s0_bottom", 131, 41, 24'hFF0000);
        probe("s0_below_bg", 100, 42, BG);
        probe("s2_only", 235, 55, 24'h00FF00);

        cyc();
        address = COLL_A;
        @(negedge clk);
`ifdef VGA_COLLISION_EN
        chk("collision", data_out, 32'h6);
        cyc();
        wr(COLL_A, 32'h2);
        address = COLL_A;
        @(negedge clk);
        chk("collision_clear", data_out, 32'h4);
`else
        chk("collision_absent", data_out, 32'h0);
`endif
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
